// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: one outstanding wait-style memory request feeding a
// DEPTH-entry prefetch queue, with branch redirect and store-driven invalidation.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_wait,
  input  logic [31:0]                imem_data,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       inval,
  input  logic [XLEN-1:0]            inval_addr,
  input  logic [1:0]                 inval_size,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state_reg, state_next;
  logic              req_reg;
  logic [XLEN-1:0]   addr_reg, addr_next;
  logic [XLEN-1:0]   fetch_pc_reg, fetch_next;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];

  logic              pop, complete, push_en, kill;
  logic [CNT_W-1:0]  pop_cnt;
  logic [PTR_W-1:0]  wr_idx, match_idx;
  logic [XLEN-1:0]   inval_span, inval_end, match_pc;
  logic [DEPTH-1:0]  slot_hit;
  logic              q_hit, req_hit;
  logic [CNT_W-1:0]  match_off;

  // A store spans at most two words, so the range test reduces to two word compares.
  function automatic logic word_hit(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] lo,
                                    input logic [XLEN-1:0] hi);
    return (((pc ^ lo) & WORD_MASK) == '0) || (((pc ^ hi) & WORD_MASK) == '0);
  endfunction

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign count     = count_reg;
  assign out_valid = (count_reg != '0);
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign out_instr = instr_mem[rd_ptr_reg];

  assign pop      = out_valid && out_ready;
  assign pop_cnt  = CNT_W'(pop);
  assign complete = req_reg && !imem_wait;
  assign wr_idx   = rd_ptr_reg + count_reg[PTR_W-1:0];

  always_comb begin
    case (inval_size)
      2'b00:   inval_span = XLEN'(0);
      2'b01:   inval_span = XLEN'(1);
      default: inval_span = XLEN'(3);
    endcase
  end
  assign inval_end = inval_addr + inval_span;

  // Slot gi is gi entries behind the head; it is live if it survives this cycle's pop.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PTR_W-1:0] idx;
    assign idx = rd_ptr_reg + PTR_W'(gi);
    assign slot_hit[gi] = (CNT_W'(gi) >= pop_cnt) && (CNT_W'(gi) < count_reg) &&
                          word_hit(pc_mem[idx], inval_addr, inval_end);
  end

  always_comb begin
    q_hit     = 1'b0;
    match_off = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        q_hit     = 1'b1;
        match_off = CNT_W'(i);
      end
    end
  end
  assign match_idx = rd_ptr_reg + match_off[PTR_W-1:0];
  assign match_pc  = pc_mem[match_idx];
  assign req_hit   = (state_reg == REQ) && word_hit(addr_reg, inval_addr, inval_end);

  always_comb begin
    push_en    = (state_reg == REQ) && complete;
    kill       = 1'b0;
    fetch_next = push_en ? addr_reg + XLEN'(4) : fetch_pc_reg;
    count_next = count_reg - pop_cnt + CNT_W'(push_en);
    if (redirect) begin
      push_en    = 1'b0;
      kill       = (state_reg == REQ);
      fetch_next = redirect_pc & WORD_MASK;
      count_next = '0;
    end else if (inval && q_hit) begin
      push_en    = 1'b0;
      kill       = (state_reg == REQ);
      fetch_next = match_pc;
      count_next = match_off - pop_cnt;
    end else if (inval && req_hit) begin
      push_en    = 1'b0;
      kill       = 1'b1;
      fetch_next = addr_reg;
      count_next = count_reg - pop_cnt;
    end
    // A pending request holds its address; a killed one finishes in DISCARD.
    if (req_reg && !complete) begin
      state_next = (state_reg == DISCARD || kill) ? DISCARD : REQ;
      addr_next  = addr_reg;
    end else begin
      state_next = (count_next < CNT_W'(DEPTH)) ? REQ : IDLE;
      addr_next  = fetch_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= (state_next != IDLE);
      addr_reg     <= addr_next;
      fetch_pc_reg <= fetch_next;
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(pop);
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_idx]    <= addr_reg;
      instr_mem[wr_idx] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: cycle table for the directed corners, then a
// program-order/memory-content reference model under random traffic.
`timescale 1ns/1ps
module tb_fetch_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_wait = 1'b0;
  logic [31:0] imem_addr, imem_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;
  logic        redirect = 1'b0, inval = 1'b0;
  logic [31:0] redirect_pc = '0, inval_addr = '0;
  logic [1:0]  inval_size = '0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_wait(imem_wait), .imem_data(imem_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .inval(inval),
    .inval_addr(inval_addr), .inval_size(inval_size), .count(count)
  );

  int checks = 0;
  int failures = 0;
  int unsigned ver [int unsigned];     // store count per memory word
  logic [31:0] exp_pc;                 // next instruction decode must see
  int pops = 0;
  int xfers = 0;
  bit saw_wrap = 1'b0;

  typedef struct {
    logic rst, mw, rdy, rd; logic [31:0] rpc; logic iv; logic [31:0] ia; logic [1:0] isz;
    logic chk, e_req; logic [31:0] e_addr; logic [2:0] e_cnt; logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] ival(input logic [31:0] pc, input int unsigned v);
    return pc ^ 32'h0000_0013 ^ (v << 20);
  endfunction

  function automatic logic [31:0] content(input logic [31:0] pc);
    int unsigned w;
    w = pc >> 2;
    return ival(pc, ver.exists(w) ? ver[w] : 0);
  endfunction

  task automatic bump(input int unsigned w);
    ver[w] = (ver.exists(w) ? ver[w] : 0) + 1;
  endtask

  task automatic apply_store(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] e;
    e = a + ((sz == 2'b00) ? 32'd0 : (sz == 2'b01) ? 32'd1 : 32'd3);
    bump(a >> 2);
    if ((e >> 2) != (a >> 2)) bump(e >> 2);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory answers from the current image; a store lands at the edge it is presented.
  task automatic tick();
    logic st;
    logic [31:0] sa;
    logic [1:0] ss;
    st = inval && !rst;
    sa = inval_addr;
    ss = inval_size;
    imem_data = content(imem_addr);
    @(posedge clk);
    if (st) apply_store(sa, ss);
    @(negedge clk);
  endtask

  task automatic row(input logic r, mw, rdy, rd, input logic [31:0] rpc, input logic iv,
                     input logic [31:0] ia, input logic [1:0] isz, input logic c, eq,
                     input logic [31:0] ea, input logic [2:0] ec, input logic [31:0] ep, ei);
    vec_t v;
    v.rst = r; v.mw = mw; v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.iv = iv; v.ia = ia;
    v.isz = isz; v.chk = c; v.e_req = eq; v.e_addr = ea; v.e_cnt = ec; v.e_pc = ep;
    v.e_instr = ei;
    tbl.push_back(v);
  endtask

  // One model-checked cycle: every pop must be the next in-order PC with current memory data.
  task automatic cycle(input logic rdy, mw, rd, input logic [31:0] rpc, input logic iv,
                       input logic [31:0] ia, input logic [1:0] isz);
    chk("count_le_depth", 64'(count <= 3'(DEPTH)), 64'd1);
    if (out_valid && rdy) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, content(exp_pc));
      if (exp_pc == 32'h0) saw_wrap = 1'b1;
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (rd) exp_pc = rpc & ~32'd3;
    if (imem_req && !mw) xfers++;
    out_ready = rdy; imem_wait = mw; redirect = rd; redirect_pc = rpc;
    inval = iv; inval_addr = ia; inval_size = isz;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int drain_pops;
    // rst mw rdy rd rpc iv ia isz | chk req addr cnt pc instr
    row(1,0,1,0,0,0,0,0, 0,0,0,0,0,0);
    row(0,0,1,0,0,0,0,0, 1,0,0,0,0,0);
    row(0,0,1,0,0,0,0,0, 1,1,'h100,0,0,0);
    row(0,0,1,0,0,0,0,0, 1,1,'h104,1,'h100,ival('h100,0));
    row(0,1,0,0,0,0,0,0, 1,1,'h108,1,'h104,ival('h104,0));
    row(0,1,0,0,0,0,0,0, 1,1,'h108,1,'h104,ival('h104,0));
    row(0,1,0,0,0,0,0,0, 1,1,'h108,1,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h108,1,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h10C,2,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h110,3,'h104,ival('h104,0));
    row(0,0,0,0,0,1,'h10A,0, 1,0,0,4,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h108,1,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h10C,2,'h104,ival('h104,0));
    row(0,1,0,0,0,1,'h10E,2, 1,1,'h110,3,'h104,ival('h104,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h110,2,'h104,ival('h104,0));
    row(0,0,1,0,0,0,0,0, 1,1,'h10C,2,'h104,ival('h104,0));
    row(0,0,1,0,0,0,0,0, 1,1,'h110,2,'h108,ival('h108,1));
    row(0,1,0,0,0,0,0,0, 1,1,'h114,2,'h10C,ival('h10C,1));
    row(0,1,0,1,'h2003,0,0,0, 1,1,'h114,2,'h10C,ival('h10C,1));
    row(0,0,0,0,0,0,0,0, 1,1,'h114,0,0,0);
    row(0,0,1,0,0,0,0,0, 1,1,'h2000,0,0,0);
    row(0,1,0,1,'h3000,1,'h2000,2, 1,1,'h2004,1,'h2000,ival('h2000,0));
    row(0,0,0,0,0,0,0,0, 1,1,'h2004,0,0,0);
    row(0,0,0,0,0,0,0,0, 1,1,'h3000,0,0,0);
    row(0,1,0,0,0,0,0,0, 1,1,'h3004,1,'h3000,ival('h3000,0));
    row(1,1,0,0,0,0,0,0, 1,1,'h3004,1,'h3000,ival('h3000,0));
    row(0,0,1,0,0,0,0,0, 1,0,0,0,0,0);
    row(0,0,1,0,0,0,0,0, 1,1,'h100,0,0,0);
    row(0,0,0,0,0,0,0,0, 1,1,'h104,1,'h100,ival('h100,0));

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.chk) begin
        chk($sformatf("row%0d imem_req", i), imem_req, v.e_req);
        if (v.e_req) chk($sformatf("row%0d imem_addr", i), imem_addr, v.e_addr);
        chk($sformatf("row%0d count", i), count, v.e_cnt);
        chk($sformatf("row%0d out_valid", i), out_valid, v.e_cnt != 0);
        if (v.e_cnt != 0) begin
          chk($sformatf("row%0d out_pc", i), out_pc, v.e_pc);
          chk($sformatf("row%0d out_instr", i), out_instr, v.e_instr);
        end
      end
      rst = v.rst; imem_wait = v.mw; out_ready = v.rdy; redirect = v.rd;
      redirect_pc = v.rpc; inval = v.iv; inval_addr = v.ia; inval_size = v.isz;
      tick();
    end

    // Fill with decode stalled: exactly DEPTH transfers, then fetch parks.
    rst = 1'b1; inval = 1'b0; redirect = 1'b0;
    tick();
    rst = 1'b0;
    exp_pc = RPC;
    xfers = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("full_xfers", xfers, DEPTH);
    chk("full_count", count, DEPTH);
    chk("full_req_idle", imem_req, 1'b0);
    // Drain: one in-order delivery per cycle, fetch resuming after the last queued PC.
    drain_pops = pops;
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    chk("drain_pops", pops - drain_pops, 12);
    chk("drain_next_pc", exp_pc, 32'h130);

    // PC wrap past the top of the address space.
    cycle(1, 0, 1, 32'hFFFF_FFF9, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    chk("pc_wrap_seen", saw_wrap, 1'b1);

    // Random traffic against the in-order program / memory-image model.
    drain_pops = pops;
    for (int i = 0; i < 3000; i++) begin
      logic rdy, mw, rd, iv;
      logic [31:0] rpc, ia;
      logic [1:0] isz;
      rdy = ($urandom_range(0, 3) != 0);
      mw  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 99) < 3);
      rpc = 32'h100 + $urandom_range(0, 'h300);
      iv  = ($urandom_range(0, 9) == 0);
      ia  = exp_pc - 32'd8 + 32'($urandom_range(0, 31));
      isz = 2'($urandom_range(0, 3));
      cycle(rdy, mw, rd, rpc, iv, ia, isz);
    end
    chk("random_progress", 64'(pops - drain_pops > 300), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
